keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Row-scanning, debouncing controller for the 4x4 matrix keypad. It drives one keypad row low at a time and reads the already-synchronized column lines. It debounces a single pressed key and emits one registered key code with a one-cycle valid strobe per press. It sits directly downstream of the column synchronizer, on the same internal oscillator clock, and feeds the display/decoder logic.

## Interface
- SCAN_DIV, 4096: clock cycles per scan tick (row dwell and debounce sample period); must be >= 4.
- DEBOUNCE_CNT, 8: consecutive matching ticks required to accept a press, and separately to accept a release; must be >= 1.
- clk  in  1  internal oscillator clock, same domain as col_sync.
- reset  in  1  reset, synchronous, active-low.
- col_sync  in  4  synchronized column lines; pulled up, bit low = key in that column pressed on the driven row.
- row  out  4  row drive, one-hot-low; row[r]=0 drives row r.
- key  out  4  hex code of the last accepted key; holds until the next accepted key.
- key_valid  out  1  one-cycle strobe, high in the cycle `key` takes a new value.

## Operation
- Tick divider: counts 0..SCAN_DIV-1 and wraps; tick = (div == SCAN_DIV-1). All sampling and state decisions happen only on tick cycles.
- "Single press" on a tick means col_sync has exactly one bit low. Zero or >=2 low bits count as "no single press".
- States: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - On a tick with a single press: latch row index r and column index c, set db=1, freeze the row, go to DEBOUNCE.
  - On a tick without a single press: rotate the row 1110->1101->1011->0111->1110.
- DEBOUNCE (row frozen), on each tick:
  - Same single column c still low: db increments.
  - When db reaches DEBOUNCE_CNT: load key, pulse key_valid, go to HELD. With DEBOUNCE_CNT=1, this fires in the cycle after the detection tick.
  - Otherwise: clear db, rotate the row, go to SCAN.
- HELD (row frozen):
  - On a tick with col_sync==4'b1111: set db=1 and go to RELEASE. Otherwise stay.
  - No auto-repeat.
- RELEASE (row frozen), on each tick:
  - All columns high: db increments. When db reaches DEBOUNCE_CNT, clear db, rotate the row, go to SCAN.
  - Any column low: go back to HELD.
- Key map, row r / col c:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D
  - For example, r1/c2 = 4'h6 and r3/c0 = 4'hE.
- Multi-key:
  - A second key pressed while HELD is ignored.
  - Two keys in one row never qualify as a single press.
  - A key held through release of another is not re-reported until it is fully released and rescanned.

## Timing
- Reset values, one edge after reset low: row=4'b1110, key=4'h0, key_valid=0, state=SCAN, div=0, db=0. A pending strobe is dropped.
- Reset mid-operation behaves identically; no partial key is emitted.
- Row changes take effect the cycle after the tick. The 2-cycle synchronizer latency is covered because sampling occurs SCAN_DIV-1 cycles later.
- Press latency: key_valid is high in the cycle after the DEBOUNCE_CNT-th matching tick, i.e. (DEBOUNCE_CNT-1)*SCAN_DIV+1 cycles after the detection tick.
- key_valid is exactly 1 cycle wide, at most once per press.
- Counter widths:
  - div is $clog2(SCAN_DIV) bits and wraps to 0, never overflowing.
  - db is $clog2(DEBOUNCE_CNT+1) bits and saturates at DEBOUNCE_CNT.
- Simultaneous tick and reset: reset wins.

## Test plan
- Reset: hold reset=0 for 3 cycles with col_sync=4'b0000 -> row=4'b1110, key=0, key_valid=0. After release, no strobe for 10 ticks with col_sync=4'b1111.
- Clean press, SCAN_DIV=8 and DEBOUNCE_CNT=3: hold col_sync=4'b1011 only while row=4'b1101 drives, then keep it pressed -> key=4'h6 with a single 1-cycle key_valid 17 cycles after the detection tick. row stays 4'b1101 until release.
- Bounce: press r0/c0, then col_sync=4'b1111 on the 2nd tick -> no key_valid, return to SCAN with row advancing to 4'b1101. A subsequent stable press gives key=4'h1.
- Hold and release: hold r3/c1 for 20 ticks -> exactly one strobe with key=4'h0. Release with a 1-tick glitch low during RELEASE -> back to HELD, no second strobe. A clean release followed by a re-press gives a second strobe.
- Multi-key: col_sync=4'b1001 on any row -> never strobes. While HELD on '5', press '9' -> no strobe for '9' until '5' is released.
- Reset mid-debounce: assert reset one cycle before the strobe would fire -> key_valid stays 0, key=0, row=4'b1110.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: column sense in, row drive and debounced key code out.
// The scanner takes the master side; the keypad/decoder side takes the slave side.
interface keypad_scanner_if;
  logic [3:0] col_sync;
  logic [3:0] row;
  logic [3:0] key;
  logic       key_valid;

  modport master (
    input  col_sync,
    output row,
    output key,
    output key_valid
  );

  modport slave (
    output col_sync,
    input  row,
    input  key,
    input  key_valid
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with press/release debounce; emits one registered
// key code and a single-cycle strobe per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV     = 4096,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master bus
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DB_W-1:0]  db_q, db_d;
  logic [3:0]       row_q, row_d;
  logic [1:0]       r_q, r_d;
  logic [1:0]       c_q, c_d;
  logic [3:0]       key_q, key_d;
  logic             key_valid_q, key_valid_d;

  logic             tick;
  logic             single;
  logic [1:0]       c_idx;
  logic [1:0]       r_idx;
  logic [DB_W-1:0]  db_inc;
  logic [3:0]       row_rot;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Exactly one low column is a single press; anything else is treated as no press.
  always_comb begin
    single = 1'b1;
    c_idx  = 2'd0;
    case (bus.col_sync)
      4'b1110: c_idx = 2'd0;
      4'b1101: c_idx = 2'd1;
      4'b1011: c_idx = 2'd2;
      4'b0111: c_idx = 2'd3;
      default: single = 1'b0;
    endcase
  end

  always_comb begin
    case (row_q)
      4'b1110: r_idx = 2'd0;
      4'b1101: r_idx = 2'd1;
      4'b1011: r_idx = 2'd2;
      default: r_idx = 2'd3;
    endcase
  end

  assign tick    = (div_q == DIV_LAST);
  assign db_inc  = (db_q == DB_MAX) ? DB_MAX : db_q + DB_W'(1);
  assign row_rot = {row_q[2:0], row_q[3]};

  always_comb begin
    state_d     = state_q;
    div_d       = tick ? '0 : div_q + DIV_W'(1);
    db_d        = db_q;
    row_d       = row_q;
    r_d         = r_q;
    c_d         = c_q;
    key_d       = key_q;
    key_valid_d = 1'b0;

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (single) begin
            r_d  = r_idx;
            c_d  = c_idx;
            db_d = DB_W'(1);
            // A one-tick debounce accepts the key on the detection tick itself.
            if (DEBOUNCE_CNT == 1) begin
              key_d       = key_map(r_idx, c_idx);
              key_valid_d = 1'b1;
              state_d     = HELD;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            row_d = row_rot;
          end
        end
        DEBOUNCE: begin
          if (single && (c_idx == c_q)) begin
            db_d = db_inc;
            if (db_inc == DB_MAX) begin
              key_d       = key_map(r_q, c_q);
              key_valid_d = 1'b1;
              state_d     = HELD;
            end
          end else begin
            db_d    = '0;
            row_d   = row_rot;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (bus.col_sync == 4'b1111) begin
            db_d    = DB_W'(1);
            state_d = RELEASE;
          end
        end
        default: begin
          if (bus.col_sync == 4'b1111) begin
            db_d = db_inc;
            if (db_inc == DB_MAX) begin
              db_d    = '0;
              row_d   = row_rot;
              state_d = SCAN;
            end
          end else begin
            state_d = HELD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= SCAN;
      div_q       <= '0;
      db_q        <= '0;
      row_q       <= 4'b1110;
      r_q         <= 2'd0;
      c_q         <= 2'd0;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      db_q        <= db_d;
      row_q       <= row_d;
      r_q         <= r_d;
      c_q         <= c_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign bus.row       = row_q;
  assign bus.key       = key_q;
  assign bus.key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad matrix model drives col_sync from
// the row drive, and expected key codes queue up until each strobe arrives.
module tb_keypad_scanner;

  logic clk;
  logic reset;
  keypad_scanner_if bus();

  logic [15:0] mask;        // bit r*4+c set = key at row r / col c held down
  logic        force_en;
  logic [3:0]  force_val;
  logic [3:0]  model_col;

  int compared;
  int mismatched;
  int cyc;
  int strobes;
  int t_strobe;
  int c_rst;
  logic prev_valid;
  logic [3:0] sb[$];

  keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_CNT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    model_col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!bus.row[r])
        for (int c = 0; c < 4; c++)
          if (mask[r*4+c]) model_col[c] = 1'b0;
  end

  assign bus.col_sync = force_en ? force_val : model_col;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; every strobe is checked against the scoreboard as it appears.
  task automatic step();
    logic [3:0] exp_k;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.key_valid === 1'b1) begin
      strobes++;
      t_strobe = cyc;
      $display("strobe key=%0h cycle=%0d row=%b", bus.key, cyc, bus.row);
      check("strobe_width", 32'(prev_valid), 0);
      check("strobe_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_k = sb.pop_front();
        check("key_code", 32'(bus.key), 32'(exp_k));
      end
    end
    prev_valid = bus.key_valid;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    steps(3);
    reset = 1'b1;
    c_rst = cyc;
  endtask

  // Waits for the row drive to change into val; returns the cycle it did.
  task automatic wait_row(input logic [3:0] val, input int budget, output int t);
    logic [3:0] prev;
    bit hit;
    hit = 1'b0;
    t = 0;
    for (int n = 0; n < budget && !hit; n++) begin
      prev = bus.row;
      step();
      if (bus.row == val && prev != val) begin
        hit = 1'b1;
        t = cyc;
      end
    end
    check("row_reached", 32'(hit), 1);
  endtask

  task automatic wait_strobe(input int budget);
    int s0;
    s0 = strobes;
    for (int n = 0; n < budget && strobes == s0; n++) step();
    check("strobe_seen", 32'(strobes - s0), 1);
  endtask

  initial begin
    int t_row;
    int t_tmp;
    int s0;
    compared = 0; mismatched = 0; cyc = 0; strobes = 0; t_strobe = 0; c_rst = 0;
    prev_valid = 1'b0;
    mask = '0;
    force_en = 1'b1;
    force_val = 4'b0000;

    // Reset with every column low
    reset = 1'b0;
    steps(3);
    check("rst_row", 32'(bus.row), 32'(4'b1110));
    check("rst_key", 32'(bus.key), 0);
    check("rst_valid", 32'(bus.key_valid), 0);
    reset = 1'b1;
    c_rst = cyc;
    force_en = 1'b0;
    steps(80);
    check("idle_no_strobe", 32'(strobes), 0);

    // Clean press of '6' (row 1, col 2)
    do_reset();
    mask = 16'(1) << (1*4 + 2);
    wait_row(4'b1101, 20, t_row);
    sb.push_back(4'h6);
    wait_strobe(40);
    check("press_latency", 32'(t_strobe - t_row), 24);
    check("row_frozen", 32'(bus.row), 32'(4'b1101));
    steps(80);
    check("row_held", 32'(bus.row), 32'(4'b1101));
    check("key_held6", 32'(bus.key), 32'(4'h6));
    mask = '0;
    wait_row(4'b1011, 60, t_tmp);
    check("key_kept6", 32'(bus.key), 32'(4'h6));

    // Bounce: r0/c0 lost on the second tick
    do_reset();
    s0 = strobes;
    mask = 16'(1);
    steps(8);
    mask = '0;
    steps(8);
    check("bounce_row", 32'(bus.row), 32'(4'b1101));
    check("bounce_no_strobe", 32'(strobes - s0), 0);
    mask = 16'(1);
    sb.push_back(4'h1);
    wait_strobe(200);
    mask = '0;
    steps(64);

    // Hold r3/c1, glitch during release, then re-press
    do_reset();
    mask = 16'(1) << (3*4 + 1);
    sb.push_back(4'h0);
    wait_strobe(200);
    s0 = strobes;
    steps(160);
    check("key_held0", 32'(bus.key), 32'(4'h0));
    while (((cyc - c_rst) % 8) != 0) step();
    mask = '0;
    steps(8);
    mask = 16'(1) << (3*4 + 1);
    steps(8);
    mask = '0;
    steps(16);
    check("glitch_back_held", 32'(bus.row), 32'(4'b0111));
    steps(8);
    check("release_rotates", 32'(bus.row), 32'(4'b1110));
    check("glitch_no_strobe", 32'(strobes - s0), 0);
    mask = 16'(1) << (3*4 + 1);
    sb.push_back(4'h0);
    wait_strobe(200);
    mask = '0;
    steps(64);

    // Multi-key cases
    do_reset();
    s0 = strobes;
    force_en = 1'b1;
    force_val = 4'b1001;
    steps(80);
    force_en = 1'b0;
    mask = (16'(1) << (2*4 + 1)) | (16'(1) << (2*4 + 2));
    steps(80);
    check("double_no_strobe", 32'(strobes - s0), 0);
    mask = 16'(1) << (1*4 + 1);
    sb.push_back(4'h5);
    wait_strobe(200);
    s0 = strobes;
    mask = mask | (16'(1) << (2*4 + 2));
    steps(80);
    check("second_key_ignored", 32'(strobes - s0), 0);
    check("key_still5", 32'(bus.key), 32'(4'h5));
    mask = 16'(1) << (2*4 + 2);
    sb.push_back(4'h9);
    wait_strobe(200);
    check("key_now9", 32'(bus.key), 32'(4'h9));
    mask = '0;
    wait_row(4'b1110, 300, t_tmp);

    // Reset one cycle before the strobe would fire
    s0 = strobes;
    mask = 16'(1);
    steps(23);
    reset = 1'b0;
    step();
    check("midrst_valid", 32'(bus.key_valid), 0);
    check("midrst_key", 32'(bus.key), 0);
    check("midrst_row", 32'(bus.row), 32'(4'b1110));
    steps(2);
    mask = '0;
    reset = 1'b1;
    c_rst = cyc;
    steps(80);
    check("midrst_no_strobe", 32'(strobes - s0), 0);

    check("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
